// File: rtl/fb_pkg.sv
// Shared defaults and state encoding for the double-buffered framebuffer arbiter.
package fb_pkg;

    localparam int unsigned FB_FRAME_WORDS = 4800;
    localparam int unsigned FB_ADDR_WIDTH  = 13;
    localparam int unsigned FB_DROP_WIDTH  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READY  = 2'd1,
        LOCKED = 2'd2
    } fb_arb_state_t;

endpackage

// File: rtl/fb_rd_addr_gen.sv
// Read word-address counter for the locked frame: clear, increment, and a
// registered last-word flag that follows the address.
module fb_rd_addr_gen
    import fb_pkg::*;
#(
    parameter int unsigned FRAME_WORDS = FB_FRAME_WORDS,
    parameter int unsigned ADDR_WIDTH  = FB_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  inc,
    input  logic                  valid_next,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_last
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_WORDS - 1);

    logic [ADDR_WIDTH-1:0] addr_next;

    // Next address: clear wins over increment.
    always_comb begin
        addr_next = rd_addr;
        if (clr) begin
            addr_next = '0;
        end else if (inc) begin
            addr_next = rd_addr + ADDR_WIDTH'(1);
        end
    end

    // Address and last flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_addr <= '0;
            rd_last <= 1'b0;
        end else begin
            rd_addr <= addr_next;
            rd_last <= valid_next && (addr_next == LAST_ADDR);
        end
    end

endmodule

// File: rtl/fb_arbiter.sv
// Ping-pong framebuffer arbiter between a camera writer and a frame reader.
// Optional macro FB_ARB_DROP_COUNT_EN enables the saturating dropped-frame
// counter; when undefined drop_count is tied to zero.
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned FRAME_WORDS = FB_FRAME_WORDS,
    parameter int unsigned ADDR_WIDTH  = FB_ADDR_WIDTH
) (
    input  logic                  cam_pclk,
    input  logic                  rst_n,
    input  logic                  frame_done,
    input  logic                  rd_req,
    input  logic                  rd_next,
    output logic                  wr_buf_sel,
    output logic                  rd_buf_sel,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_valid,
    output logic                  rd_last,
    output logic                  frame_avail,
    output logic [7:0]            drop_count
);

    fb_arb_state_t state, state_next;
    logic          swap;
    logic          drop;
    logic          addr_clr;
    logic          addr_inc;

    // State register plus registered status flags derived from next state.
    always_ff @(posedge cam_pclk) begin
        if (!rst_n) begin
            state       <= IDLE;
            rd_valid    <= 1'b0;
            frame_avail <= 1'b0;
        end else begin
            state       <= state_next;
            rd_valid    <= (state_next == LOCKED);
            frame_avail <= (state_next == READY);
        end
    end

    // Next-state, swap, drop and address control.
    always_comb begin
        state_next = state;
        swap       = 1'b0;
        drop       = 1'b0;
        addr_clr   = 1'b0;
        addr_inc   = 1'b0;
        unique case (state)
            IDLE: begin
                if (frame_done) begin
                    swap       = 1'b1;
                    state_next = READY;
                end
            end
            READY: begin
                if (rd_req) begin
                    state_next = LOCKED;
                    addr_clr   = 1'b1;
                    swap       = frame_done;
                end else if (frame_done) begin
                    swap = 1'b1;
                    drop = 1'b1;
                end
            end
            LOCKED: begin
                if (!rd_req || (rd_next && rd_last)) begin
                    // Abort or end of frame: release, picking up a fresh frame if one lands now.
                    addr_clr   = 1'b1;
                    swap       = frame_done;
                    state_next = frame_done ? READY : IDLE;
                end else begin
                    addr_inc = rd_next;
                    drop     = frame_done;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Buffer select registers; the two selects always differ.
    always_ff @(posedge cam_pclk) begin
        if (!rst_n) begin
            wr_buf_sel <= 1'b0;
            rd_buf_sel <= 1'b1;
        end else if (swap) begin
            rd_buf_sel <= wr_buf_sel;
            wr_buf_sel <= ~wr_buf_sel;
        end
    end

    fb_rd_addr_gen #(
        .FRAME_WORDS (FRAME_WORDS),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_addr_gen (
        .clk        (cam_pclk),
        .rst_n      (rst_n),
        .clr        (addr_clr),
        .inc        (addr_inc),
        .valid_next (state_next == LOCKED),
        .rd_addr    (rd_addr),
        .rd_last    (rd_last)
    );

`ifdef FB_ARB_DROP_COUNT_EN
    logic [FB_DROP_WIDTH-1:0] drop_cnt;

    // Saturating count of frames lost to overwrite.
    always_ff @(posedge cam_pclk) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + FB_DROP_WIDTH'(1);
        end
    end

    assign drop_count = drop_cnt;
`else
    logic unused_drop;
    assign unused_drop = drop;
    assign drop_count  = '0;
`endif

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 SHALL have parameter FRAME_WORDS, default 4800, meaning 16-bit words per 1-bpp frame.
REQ-002 SHALL have parameter ADDR_WIDTH, default 13, meaning the framebuffer word-address width.
REQ-003 SHALL have port cam_pclk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port frame_done  input  1  one-cycle pulse when the writer completes a frame into wr_buf_sel.
REQ-006 SHALL have port rd_req  input  1  level; reader wants/holds a frame.
REQ-007 SHALL have port rd_next  input  1  one-cycle strobe; reader consumed the current word.
REQ-008 SHALL have port wr_buf_sel  output  1  buffer the writer fills.
REQ-009 SHALL have port rd_buf_sel  output  1  buffer the reader drains.
REQ-010 SHALL have port rd_addr  output  ADDR_WIDTH  registered read word address.
REQ-011 SHALL have port rd_valid  output  1  high while the reader holds a locked frame.
REQ-012 SHALL have port rd_last  output  1  high when rd_valid and rd_addr==FRAME_WORDS-1.
REQ-013 SHALL have port frame_avail  output  1  an unread complete frame is in rd_buf_sel.
REQ-014 SHALL have port drop_count  output  8  frames lost, saturating.

Function
REQ-015 SHALL implement states IDLE (no frame), READY (frame available, unlocked) and LOCKED (reader streaming).
REQ-016 SHALL define swap as rd_buf_sel<=wr_buf_sel and wr_buf_sel<=~wr_buf_sel on one edge; wr_buf_sel != rd_buf_sel always.
REQ-017 IDLE: frame_done SHALL swap and go to READY; rd_req alone SHALL be ignored.
REQ-018 READY: frame_done alone SHALL swap, stay READY, and increment drop_count (the unread frame is lost).
REQ-019 READY: rd_req SHALL enter LOCKED with rd_addr<=0; with simultaneous frame_done it SHALL also swap on the same edge, lock the new buffer, and not count a drop.
REQ-020 LOCKED: frame_done SHALL NOT swap and SHALL increment drop_count (writer overwrites its own buffer).
REQ-021 LOCKED: rd_next with rd_addr<FRAME_WORDS-1 SHALL increment rd_addr by 1.
REQ-022 LOCKED: rd_next with rd_last SHALL release to IDLE, or to READY with a swap and no drop if frame_done occurs in the same cycle.
REQ-023 LOCKED: rd_req low SHALL abort to IDLE (frame discarded, rd_addr<=0), with the same frame_done handling as REQ-022; abort takes priority over rd_next.
REQ-024 SHALL assert rd_valid iff LOCKED and frame_avail iff READY, both from registered state, with no combinational input-to-output path.
REQ-025 SHALL saturate drop_count at 255 and SHALL NOT wrap.
REQ-026 rd_addr SHALL be valid the cycle after the grant edge; SPRAM read latency (1 cycle) belongs to the reader.

Reset
REQ-027 With rst_n low at an edge, SHALL set state IDLE, wr_buf_sel=0, rd_buf_sel=1, rd_addr=0, rd_valid=0, rd_last=0, frame_avail=0, drop_count=0.
REQ-028 Reset mid-LOCKED SHALL drop the lock immediately without swap, regardless of other inputs.

Configuration
REQ-029 Macro FB_ARB_DROP_COUNT_EN defined: drop_count SHALL behave per REQ-018/020/025.
REQ-030 Macro FB_ARB_DROP_COUNT_EN undefined: drop_count SHALL be constant 0 and the counter SHALL not be synthesised; all other behaviour SHALL be unchanged.

Structure
REQ-031 Package fb_pkg SHALL hold FRAME_WORDS, ADDR_WIDTH defaults, and the fb_arb_state_t enum (IDLE, READY, LOCKED).
REQ-032 Sub-module fb_rd_addr_gen SHALL hold the rd_addr counter (clear, increment, last flag); the FSM, swap and drop logic SHALL stay in fb_arbiter.

Verification (FRAME_WORDS=4, ADDR_WIDTH=2)
REQ-033 Reset, then one frame_done -> wr_buf_sel=1, rd_buf_sel=0, frame_avail=1, drop_count=0.
REQ-034 From READY, rd_req high then 4 rd_next -> rd_addr 0,1,2,3, rd_last on addr 3, then IDLE with rd_valid=0.
REQ-035 Two frame_done in READY, then rd_req -> drop_count=1, and the locked buffer is the one most recently swapped.
REQ-036 frame_done during LOCKED -> buffers unchanged, drop_count+1; frame_done on the same cycle as the last rd_next -> swap, READY, no drop.
REQ-037 Simultaneous frame_done and rd_req in READY -> swap and LOCKED on one edge, rd_addr=0, drop_count unchanged.
REQ-038 300 drops -> drop_count=255; macro undefined -> drop_count=0 throughout; rst_n low mid-LOCKED -> all REQ-027 values.
